mr_keystream_gen: RTL

Parametrised Massey-Rueppel inner-product keystream generator. Two Fibonacci LFSRs (M and L) with configurable width and taps; each keystream bit is the XOR-reduction of M AND the low M_WIDTH bits of L. Adds seed-load control, a warm-up discard phase, clock-enable stepping, and an OUT_WIDTH-bit packed output with a valid/ready handshake and a one-word skid buffer. It feeds stream-cipher datapaths directly, with no clock divider.

---
 rtl/mr_keystream_gen.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mr_keystream_gen.sv
// Massey-Rueppel inner-product keystream generator: two Fibonacci LFSRs, ks = ^(M & L[M_WIDTH-1:0]), packed OUT_WIDTH bits per word.
// First word WARMUP+OUT_WIDTH+1 edges after load; generation stalls only when the collector is full and o_data is unconsumed.
module mr_keystream_gen #(
  parameter int                 M_WIDTH   = 7,
  parameter int                 L_WIDTH   = 13,
  parameter logic [M_WIDTH-1:0] M_TAPS    = 7'h60,
  parameter logic [L_WIDTH-1:0] L_TAPS    = 13'h100D,
  parameter int                 WARMUP    = 16,
  parameter int                 OUT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [M_WIDTH-1:0]   i_seed_lfsrM,
  input  logic [L_WIDTH-1:0]   i_seed_lfsrL,
  input  logic                 i_enable,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic [M_WIDTH-1:0]   o_lfsrM,
  output logic [L_WIDTH-1:0]   o_lfsrL,
  output logic                 o_keystream,
  output logic                 o_busy
);

  localparam int CW = $clog2(OUT_WIDTH + 1);
  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0] CNT_FULL  = CW'(OUT_WIDTH);
  localparam logic [WW-1:0] WARM_INIT = WW'(WARMUP);

  typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;

  state_t               state, state_n;
  logic [M_WIDTH-1:0]   m, m_n, m_step;
  logic [L_WIDTH-1:0]   l, l_n, l_step;
  logic [OUT_WIDTH-1:0] coll, coll_n;
  logic [OUT_WIDTH-1:0] data, data_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [WW-1:0]        warm, warm_n;
  logic                 valid, valid_n;
  logic                 ks;

  assign m_step = {m[M_WIDTH-2:0], ^(m & M_TAPS)};
  assign l_step = {l[L_WIDTH-2:0], ^(l & L_TAPS)};
  assign ks     = ^(m & l[M_WIDTH-1:0]);

  always_comb begin
    state_n = state;
    m_n     = m;
    l_n     = l;
    coll_n  = coll;
    data_n  = data;
    cnt_n   = cnt;
    warm_n  = warm;
    valid_n = valid;
    if (i_load) begin
      // An all-zero seed would lock the LFSR, so it is replaced by 1.
      m_n     = (i_seed_lfsrM == '0) ? M_WIDTH'(1) : i_seed_lfsrM;
      l_n     = (i_seed_lfsrL == '0) ? L_WIDTH'(1) : i_seed_lfsrL;
      cnt_n   = '0;
      coll_n  = '0;
      valid_n = 1'b0;
      warm_n  = WARM_INIT;
      state_n = (WARMUP > 0) ? WARM : RUN;
    end else begin
      if (valid && i_ready) valid_n = 1'b0;
      case (state)
        IDLE: ;
        WARM: begin
          if (i_enable) begin
            m_n    = m_step;
            l_n    = l_step;
            warm_n = warm - WW'(1);
            if (warm == WW'(1)) state_n = RUN;
          end
        end
        RUN: begin
          if (i_enable) begin
            if (cnt != CNT_FULL) begin
              for (int i = 0; i < OUT_WIDTH; i++) begin
                if (cnt == CW'(i)) coll_n[i] = ks;
              end
              cnt_n = cnt + CW'(1);
              m_n   = m_step;
              l_n   = l_step;
            end else if (!valid || i_ready) begin
              // Hand-off also covers the consume-and-refill case in one edge.
              data_n  = coll;
              valid_n = 1'b1;
              cnt_n   = '0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      m     <= M_WIDTH'(1);
      l     <= L_WIDTH'(1);
      coll  <= '0;
      data  <= '0;
      cnt   <= '0;
      warm  <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      m     <= m_n;
      l     <= l_n;
      coll  <= coll_n;
      data  <= data_n;
      cnt   <= cnt_n;
      warm  <= warm_n;
      valid <= valid_n;
    end
  end

  assign o_valid     = valid;
  assign o_data      = data;
  assign o_lfsrM     = m;
  assign o_lfsrL     = l;
  assign o_keystream = ks;
  assign o_busy      = (state != IDLE);

endmodule
